// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional macro IF_ADEF_CHECK_EN enables fetch address-error detection.
package if_stage_pkg;

    localparam int unsigned IF_ADDR_W      = 32;
    localparam logic [31:0] IF_RESET_PC    = 32'hbfc00000;
    localparam int unsigned FS_TO_DS_BUS_W = 65;
    localparam int unsigned BR_BUS_W       = 34;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } if_state_t;

    // IF -> ID payload: pc + inst + adef
    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_bus_t;

    // ID -> IF redirect: valid + taken + target
    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // True when a PC is not word aligned
    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_next_pc.sv
// Next fetch PC selection: same-cycle redirect, latched redirect, or sequential +4.
module if_stage_next_pc
    import if_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = IF_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_fetch_pc,
    input  logic              i_redir_pend,
    input  logic [ADDR_W-1:0] i_redir_pc,
    input  br_bus_t           i_br,
    output logic [ADDR_W-1:0] o_next_pc_c
);

    // A redirect arriving on the handoff cycle bypasses the latch
    always_comb begin
        o_next_pc_c = i_fetch_pc + ADDR_W'(4);
        if (i_redir_pend) begin
            o_next_pc_c = i_redir_pc;
        end
        if (i_br.valid && i_br.taken) begin
            o_next_pc_c = ADDR_W'(i_br.target);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding fetch, output buffer toward ID,
// delayed-branch redirect. Optional macro IF_ADEF_CHECK_EN flags unaligned PCs.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = IF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ds_allowin,
    input  logic              i_br_valid,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic              o_inst_req,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic              i_inst_addr_ok,
    input  logic              i_inst_data_ok,
    input  logic [31:0]       i_inst_rdata,
    output logic              o_fs_to_ds_valid,
    output logic [ADDR_W-1:0] o_fs_pc,
    output logic [31:0]       o_fs_inst,
    output logic              o_fs_adef
);

    if_state_t         r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inst_req;
    logic              r_fs_valid;
    logic [ADDR_W-1:0] r_fs_pc;
    logic [31:0]       r_fs_inst;
    logic              r_redir_pend;
    logic [ADDR_W-1:0] r_redir_pc;

    br_bus_t           w_br;
    logic [ADDR_W-1:0] w_next_pc_c;
    logic              w_handoff;
    logic              w_idle_req;
    logic              w_next_req;

    assign w_br      = '{valid: i_br_valid, taken: i_br_taken, target: 32'(i_br_target)};
    assign w_handoff = (r_state == S_VALID) && i_ds_allowin;

`ifdef IF_ADEF_CHECK_EN
    logic r_fs_adef;
    logic w_misaligned;
    assign w_misaligned = pc_misaligned(r_fetch_pc[1:0]);
    assign w_idle_req   = !w_misaligned;
    assign w_next_req   = !pc_misaligned(w_next_pc_c[1:0]);
    assign o_fs_adef    = r_fs_adef;
`else
    assign w_idle_req   = 1'b1;
    assign w_next_req   = 1'b1;
    assign o_fs_adef    = 1'b0;
`endif

    assign o_inst_req       = r_inst_req;
    assign o_inst_addr      = r_fetch_pc;
    assign o_fs_to_ds_valid = r_fs_valid;
    assign o_fs_pc          = r_fs_pc;
    assign o_fs_inst        = r_fs_inst;

    if_stage_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .i_fetch_pc   (r_fetch_pc),
        .i_redir_pend (r_redir_pend),
        .i_redir_pc   (r_redir_pc),
        .i_br         (w_br),
        .o_next_pc_c  (w_next_pc_c)
    );

    // Fetch FSM, output buffer and pending-redirect latch
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_inst_req   <= 1'b0;
            r_fs_valid   <= 1'b0;
            r_fs_pc      <= '0;
            r_fs_inst    <= '0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
`ifdef IF_ADEF_CHECK_EN
            r_fs_adef    <= 1'b0;
`endif
        end else begin
            if (w_br.valid && w_br.taken && !w_handoff) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= i_br_target;
            end
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_inst_req <= w_idle_req;
                end
                S_REQ: begin
`ifdef IF_ADEF_CHECK_EN
                    if (w_misaligned) begin
                        r_state    <= S_VALID;
                        r_inst_req <= 1'b0;
                        r_fs_valid <= 1'b1;
                        r_fs_pc    <= r_fetch_pc;
                        r_fs_inst  <= '0;
                        r_fs_adef  <= 1'b1;
                    end else
`endif
                    if (i_inst_addr_ok) begin
                        r_inst_req <= 1'b0;
                        if (i_inst_data_ok) begin
                            r_state    <= S_VALID;
                            r_fs_valid <= 1'b1;
                            r_fs_pc    <= r_fetch_pc;
                            r_fs_inst  <= i_inst_rdata;
`ifdef IF_ADEF_CHECK_EN
                            r_fs_adef  <= 1'b0;
`endif
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_inst_data_ok) begin
                        r_state    <= S_VALID;
                        r_fs_valid <= 1'b1;
                        r_fs_pc    <= r_fetch_pc;
                        r_fs_inst  <= i_inst_rdata;
`ifdef IF_ADEF_CHECK_EN
                        r_fs_adef  <= 1'b0;
`endif
                    end
                end
                S_VALID: begin
                    if (i_ds_allowin) begin
                        r_state      <= S_REQ;
                        r_fs_valid   <= 1'b0;
                        r_fetch_pc   <= w_next_pc_c;
                        r_redir_pend <= 1'b0;
                        r_inst_req   <= w_next_req;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A second redirect while one is still pending would be lost
    a_no_double_redir: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_br_valid && r_redir_pend));

endmodule
